// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around the shared port.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  iReq;
   logic [ADDR_WIDTH-1:0] iAddr;
   logic                  iAck;
   logic [DATA_WIDTH-1:0] iRdata;
   logic                  dReq;
   logic                  dWe;
   logic [ADDR_WIDTH-1:0] dAddr;
   logic [DATA_WIDTH-1:0] dWdata;
   logic                  dAck;
   logic [DATA_WIDTH-1:0] dRdata;
   logic                  memEn;
   logic                  memWe;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWdata;
   logic [DATA_WIDTH-1:0] memRdata;
   logic                  busy;

   modport slave (
      input  iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
      output iAck, iRdata, dAck, dRdata, memEn, memWe, memAddr, memWdata, busy
   );

   modport master (
      output iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
      input  iAck, iRdata, dAck, dRdata, memEn, memWe, memAddr, memWdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one memory port, one
// multicycle transaction at a time (IDLE -> ISSUE -> WAIT -> RESP).
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic                  last_d_q;   // 1 = data port won the last grant
   logic                  owner_d_q;  // 1 = current transaction belongs to data port
   logic                  we_q;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] irdata_q;
   logic [DATA_WIDTH-1:0] drdata_q;
   logic                  grant;
   logic                  grant_d;

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.iReq || bus.dReq) begin
               grant   = 1'b1;
               grant_d = bus.dReq && (!bus.iReq || !last_d_q);
               state_d = ISSUE;
            end
         end
         ISSUE:   state_d = we_q ? RESP : WAIT;
         WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         owner_d_q   <= 1'b0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         irdata_q    <= '0;
         drdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            last_d_q   <= grant_d;
            owner_d_q  <= grant_d;
            we_q       <= grant_d & bus.dWe;
            mem_addr_q <= grant_d ? bus.dAddr : bus.iAddr;
            if (grant_d) mem_wdata_q <= bus.dWdata;
         end
         if (state_q == ISSUE && !we_q) begin
            cnt_q <= CW'(MEM_LATENCY);
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - CW'(1);
         end
         // Last WAIT cycle is exactly MEM_LATENCY cycles after memEn.
         if (state_q == WAIT && cnt_q == CW'(1)) begin
            if (owner_d_q) drdata_q <= bus.memRdata;
            else           irdata_q <= bus.memRdata;
         end
      end
   end

   // Strobes and acks decode from registered state only.
   assign bus.memEn    = (state_q == ISSUE);
   assign bus.memWe    = (state_q == ISSUE) && we_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.iAck     = (state_q == RESP) && !owner_d_q;
   assign bus.dAck     = (state_q == RESP) && owner_d_q;
   assign bus.memAddr  = mem_addr_q;
   assign bus.memWdata = mem_wdata_q;
   assign bus.iRdata   = irdata_q;
   assign bus.dRdata   = drdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LATENCY 2, 1, 4)
// each behind a latency-accurate memory model.
module tb_mem_port_arbiter;
   logic        clk;
   logic        rst_n;
   logic [2:0]  ireq, dreq, dwe;
   logic [31:0] iaddr  [3];
   logic [31:0] daddr  [3];
   logic [31:0] dwdata [3];
   logic [2:0]  iack, dack, mem_en, mem_we, busy;
   logic [31:0] irdata    [3];
   logic [31:0] drdata    [3];
   logic [31:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
      logic [31:0] pipe [4];

      assign bus.iReq   = ireq[g];
      assign bus.iAddr  = iaddr[g];
      assign bus.dReq   = dreq[g];
      assign bus.dWe    = dwe[g];
      assign bus.dAddr  = daddr[g];
      assign bus.dWdata = dwdata[g];
      assign iack[g]      = bus.iAck;
      assign dack[g]      = bus.dAck;
      assign irdata[g]    = bus.iRdata;
      assign drdata[g]    = bus.dRdata;
      assign mem_en[g]    = bus.memEn;
      assign mem_we[g]    = bus.memWe;
      assign mem_addr[g]  = bus.memAddr;
      assign mem_wdata[g] = bus.memWdata;
      assign busy[g]      = bus.busy;

      // Read data appears exactly L cycles after the memEn cycle; garbage otherwise.
      always @(posedge clk) begin
         pipe[0] <= bus.memEn ? memf(bus.memAddr) : 32'hBAD0BAD0;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign bus.memRdata = pipe[L-1];

      mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on instance k; latency counted in cycles from the sampling IDLE cycle.
   task automatic access(input int k, input bit isd, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat, input string tag);
      int n = 0;
      int en_cnt = 0;
      int en_at = 0;
      bit ack = 0;
      bit wrong = 0;
      bit busy_ok = 1;
      logic [31:0] i_before = irdata[k];
      logic [31:0] d_before = drdata[k];
      if (isd) begin
         dreq[k] = 1'b1; dwe[k] = we; daddr[k] = addr; dwdata[k] = wd;
      end else begin
         ireq[k] = 1'b1; iaddr[k] = addr;
      end
      while (!ack && n < 30) begin
         tick();
         n++;
         if (!busy[k]) busy_ok = 0;
         if (mem_en[k]) begin
            en_cnt++;
            en_at = n;
            chk({tag, " memAddr"}, mem_addr[k], addr);
            chk({tag, " memWe"}, {31'd0, mem_we[k]}, {31'd0, we});
            if (we) chk({tag, " memWdata"}, mem_wdata[k], wd);
         end
         ack = isd ? dack[k] : iack[k];
         if (isd ? iack[k] : dack[k]) wrong = 1;
      end
      chk({tag, " issue_cycle"}, en_at, 1);
      chk({tag, " latency"}, n, exp_lat);
      chk({tag, " memEn_pulses"}, en_cnt, 1);
      chk({tag, " wrong_ack"}, {31'd0, wrong}, 32'd0);
      chk({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
      if (!we) chk({tag, " rdata"}, isd ? drdata[k] : irdata[k], memf(addr));
      else     chk({tag, " drdata_kept"}, drdata[k], d_before);
      if (isd) chk({tag, " irdata_kept"}, irdata[k], i_before);
      else     chk({tag, " drdata_kept"}, drdata[k], d_before);
      ireq[k] = 1'b0;
      dreq[k] = 1'b0;
      tick();
      chk({tag, " busy_after"}, {31'd0, busy[k]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      string seq = "IDID";
      int got_ack = 0;
      int n = 0;
      int en_since = 0;
      bit late = 0;
      rst_n = 1'b0;
      ireq = '0; dreq = '0; dwe = '0;
      for (int k = 0; k < 3; k++) begin
         iaddr[k] = '0; daddr[k] = '0; dwdata[k] = '0;
      end

      // Reset held with both requests high
      ireq[0] = 1'b1; dreq[0] = 1'b1;
      iaddr[0] = 32'h40; daddr[0] = 32'h80; dwe[0] = 1'b0;
      tick();
      tick();
      chk("rst memEn", {31'd0, mem_en[0]}, 32'd0);
      chk("rst acks", {30'd0, iack[0], dack[0]}, 32'd0);
      chk("rst busy", {31'd0, busy[0]}, 32'd0);
      chk("rst memAddr", mem_addr[0], 32'd0);
      chk("rst memWdata", mem_wdata[0], 32'd0);
      chk("rst irdata", irdata[0], 32'd0);
      chk("rst drdata", drdata[0], 32'd0);

      // Release with both held: expect I, D, I, D with one memEn per ack
      rst_n = 1'b1;
      while (got_ack < 4 && n < 40) begin
         tick();
         n++;
         if (mem_en[0]) begin
            en_since++;
            chk("alt memAddr", mem_addr[0], (seq[got_ack] == "I") ? 32'h40 : 32'h80);
         end
         if (iack[0] || dack[0]) begin
            chk("alt ack_port", {30'd0, iack[0], dack[0]},
                (seq[got_ack] == "I") ? 32'd2 : 32'd1);
            chk("alt memEn_per_ack", en_since, 1);
            if (seq[got_ack] == "I") chk("alt irdata", irdata[0], memf(32'h40));
            else                     chk("alt drdata", drdata[0], memf(32'h80));
            en_since = 0;
            got_ack++;
         end
      end
      chk("alt ack_count", got_ack, 4);
      ireq[0] = 1'b0; dreq[0] = 1'b0;
      tick();

      access(0, 0, 0, 32'h100, 32'h0, 4, "fetch");
      access(0, 1, 1, 32'h200, 32'h1234, 2, "store");
      access(0, 1, 0, 32'h204, 32'h0, 4, "load");

      // Reset in the first WAIT cycle of a fetch
      ireq[0] = 1'b1; iaddr[0] = 32'h300;
      tick();
      chk("rstw issue", {31'd0, mem_en[0]}, 32'd1);
      tick();
      rst_n = 1'b0; ireq[0] = 1'b0;
      tick();
      chk("rstw busy", {31'd0, busy[0]}, 32'd0);
      chk("rstw iack", {31'd0, iack[0]}, 32'd0);
      chk("rstw irdata", irdata[0], 32'd0);
      chk("rstw memAddr", mem_addr[0], 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (iack[0] || irdata[0] != 32'd0 || busy[0]) late = 1;
      end
      chk("rstw no_late_capture", {31'd0, late}, 32'd0);
      access(0, 1, 0, 32'h55AA, 32'h0, 4, "post_rst_load");

      // Latency sweep: back-to-back loads
      access(1, 1, 0, 32'h1000, 32'h0, 3, "lat1_a");
      access(1, 1, 0, 32'h1004, 32'h0, 3, "lat1_b");
      access(2, 1, 0, 32'h2000, 32'h0, 6, "lat4_a");
      access(2, 1, 0, 32'h2008, 32'h0, 6, "lat4_b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
